led_write_arbiter: RTL and testbench
====================================

Name: led_write_arbiter

Overview:
- Shares the memory-mapped LED output register bank between two write requesters: the CPU store path and the debug/self-test pattern source.
- Arbitrates round-robin and decodes/filters the LED addresses 0x60, 0x64 and 0x68.
- Buffers accepted writes in a small FIFO and issues them to the LED register one per cycle, as a single-cycle led_ctrl strobe with address and data.
- Sits between the MMIO decode and the LED output register.

Parameters:
- FIFO_DEPTH, 4, write-buffer entries; must be a power of 2, ≥2.
- ADDR_W, 8, address width.
- DATA_W, 16, write data width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- cpu_req  in  1  CPU write request; held high while pending
- cpu_addr  in  ADDR_W  CPU write address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  combinational; high in the cycle the CPU write is consumed
- dbg_req  in  1  debug write request
- dbg_addr  in  ADDR_W  debug write address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  combinational; high in the cycle the debug write is consumed
- led_ctrl  out  1  registered single-cycle write strobe to the LED register
- led_addr  out  ADDR_W  registered address of the issued write
- led_data  out  DATA_W  registered data of the issued write
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently buffered
- busy  out  1  fifo_count!=0 or led_ctrl
- err_clr  in  1  clears bad_addr_err
- bad_addr_err  out  1  sticky: a consumed write had an address outside {0x60,0x64,0x68}

Behaviour:
- Reset (async) values:
  - led_ctrl=0, led_addr=0, led_data=0, bad_addr_err=0.
  - FIFO empty, fifo_count=0.
  - Round-robin pointer favours CPU next.
- Grant condition:
  - At most one grant per cycle.
  - A grant is only issued when the FIFO is not full at the start of the cycle.
  - A grant does not depend on this cycle's pop, so a full FIFO stalls requesters for one cycle even if it drains.
- Arbitration:
  - Only one requesting → that one is granted.
  - Both requesting → the one not granted most recently is granted.
  - The pointer updates only on a grant.
  - Each gnt cycle consumes exactly one write. A requester holding req high gets one write consumed per grant cycle.
- Address decode, at grant:
  - Address 0x60, 0x64 or 0x68 → {addr,wdata} is pushed at the clock edge ending the grant cycle.
  - Any other address → the write is consumed (gnt=1) but dropped, and bad_addr_err is set.
  - Bad-address writes never occupy the FIFO.
- Issue:
  - Registered, two-state FSM: IDLE (FIFO empty at start of cycle) / ISSUE (FIFO non-empty).
  - In ISSUE the head is popped at the clock edge: led_addr/led_data load the head and led_ctrl=1 for the following cycle.
  - Otherwise led_ctrl=0 and led_addr/led_data hold their last values.
- Latency and throughput:
  - A write granted in cycle N into an empty FIFO gives led_ctrl=1 in cycle N+2.
  - Sustained throughput is one write per cycle.
- Ordering: strict FIFO order; issue order equals grant order.
- Simultaneous push and pop: fifo_count is unchanged; pointers wrap modulo FIFO_DEPTH.
- Sticky error: if err_clr and a new bad-address grant occur in the same cycle, set wins and bad_addr_err=1.
- Reset mid-operation: buffered writes are discarded and no led_ctrl pulse is generated.

Optional Feature:
- Macro: LED_ARB_DBG_PRIORITY_EN.
- Defined: the debug requester has strict priority. dbg_req always wins over cpu_req and the round-robin pointer is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single write: after reset, cpu_req with addr=0x64, wdata=0x00A5 for one cycle (N) → cpu_gnt=1 in N; led_ctrl=1, led_addr=0x64, led_data=0x00A5 in N+2; fifo_count back to 0 in N+3.
- Contention: cpu_req and dbg_req held high, CPU addr 0x60/data 0x0001, debug addr 0x68/data 0x0002, for 4 cycles → grants alternate CPU, DBG, CPU, DBG; led_data sequence 1,2,1,2.
- Full FIFO: with FIFO_DEPTH=4, deassert issue progress is impossible, so drive 6 back-to-back CPU writes (0x60, data 1..6) → 6 gnts and 6 strobes, data order 1..6 preserved, fifo_count never exceeds 4.
- Bad address: dbg_req with addr=0x6C → dbg_gnt=1, bad_addr_err=1 from the next cycle, no led_ctrl pulse. Then err_clr coinciding with a second 0x6C write → bad_addr_err stays 1.
- Mid-operation reset: 3 writes buffered, then rst pulsed → led_ctrl=0, fifo_count=0, led_data=0; no stale strobe after reset releases.
- LED_ARB_DBG_PRIORITY_EN defined, both requesters held high for 3 cycles → dbg_gnt=1 every cycle and cpu_gnt=0.

Source files
------------

// File: rtl/led_write_arbiter.sv
// led_write_arbiter: shares the LED output register bank between the CPU store
// path and the debug/self-test pattern source. Writes are arbitrated, filtered
// to the LED addresses 0x60/0x64/0x68, buffered in a small FIFO and issued one
// per cycle as a single-cycle led_ctrl strobe.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cpu_req/cpu_addr/cpu_wdata    CPU write request (held while pending)
//   cpu_gnt                       combinational: CPU write consumed this cycle
//   dbg_req/dbg_addr/dbg_wdata    debug write request
//   dbg_gnt                       combinational: debug write consumed this cycle
//   led_ctrl/led_addr/led_data    registered write strobe, address and data
//   fifo_count                    entries currently buffered
//   busy                          fifo_count != 0 or led_ctrl
//   err_clr                       clears bad_addr_err
//   bad_addr_err                  sticky: a consumed write had a non-LED address
//
// Build option: define LED_ARB_DBG_PRIORITY_EN to give the debug requester
// strict priority instead of round-robin.
module led_write_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_req,
  input  logic [ADDR_W-1:0]               cpu_addr,
  input  logic [DATA_W-1:0]               cpu_wdata,
  output logic                            cpu_gnt,
  input  logic                            dbg_req,
  input  logic [ADDR_W-1:0]               dbg_addr,
  input  logic [DATA_W-1:0]               dbg_wdata,
  output logic                            dbg_gnt,
  output logic                            led_ctrl,
  output logic [ADDR_W-1:0]               led_addr,
  output logic [DATA_W-1:0]               led_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            busy,
  input  logic                            err_clr,
  output logic                            bad_addr_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  localparam logic [ADDR_W-1:0] LED_A0 = ADDR_W'(8'h60);
  localparam logic [ADDR_W-1:0] LED_A1 = ADDR_W'(8'h64);
  localparam logic [ADDR_W-1:0] LED_A2 = ADDR_W'(8'h68);

  logic [0:0]        state, state_next;
  logic              rr_dbg, rr_dbg_next;   // 1: debug is favoured on contention
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]  count_next;
  logic              led_ctrl_next;
  logic [ADDR_W-1:0] led_addr_next;
  logic [DATA_W-1:0] led_data_next;
  logic              err_next;
  logic              busy_next;

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  logic              full;
  logic              cpu_sel, dbg_sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_ok;
  logic              push, pop, bad;

  // Grant selection; fullness is sampled at the start of the cycle only
  always_comb begin
    full    = (fifo_count == CNT_W'(FIFO_DEPTH));
    cpu_sel = 1'b0;
    dbg_sel = 1'b0;
`ifdef LED_ARB_DBG_PRIORITY_EN
    dbg_sel = dbg_req;
    cpu_sel = cpu_req & ~dbg_req;
`else
    if (cpu_req && dbg_req) begin
      cpu_sel = ~rr_dbg;
      dbg_sel = rr_dbg;
    end else begin
      cpu_sel = cpu_req;
      dbg_sel = dbg_req;
    end
`endif
    cpu_gnt = cpu_sel & ~full;
    dbg_gnt = dbg_sel & ~full;
  end

  // Address filter and FIFO/issue next-state
  always_comb begin
    sel_addr      = dbg_gnt ? dbg_addr  : cpu_addr;
    sel_wdata     = dbg_gnt ? dbg_wdata : cpu_wdata;
    addr_ok       = (sel_addr == LED_A0) || (sel_addr == LED_A1) ||
                    (sel_addr == LED_A2);
    push          = (cpu_gnt | dbg_gnt) & addr_ok;
    bad           = (cpu_gnt | dbg_gnt) & ~addr_ok;
    pop           = (state == S_ISSUE);

    rr_dbg_next   = rr_dbg;
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    count_next    = fifo_count;
    led_ctrl_next = 1'b0;
    led_addr_next = led_addr;
    led_data_next = led_data;
    err_next      = bad_addr_err;

    if (cpu_gnt) rr_dbg_next = 1'b1;
    else if (dbg_gnt) rr_dbg_next = 1'b0;

    if (push) wr_ptr_next = wr_ptr + PTR_W'(1);

    if (pop) begin
      rd_ptr_next   = rd_ptr + PTR_W'(1);
      led_ctrl_next = 1'b1;
      led_addr_next = addr_mem[rd_ptr];
      led_data_next = data_mem[rd_ptr];
    end

    if (push && !pop)      count_next = fifo_count + CNT_W'(1);
    else if (pop && !push) count_next = fifo_count - CNT_W'(1);

    // Set wins over a coincident clear
    if (bad)          err_next = 1'b1;
    else if (err_clr) err_next = 1'b0;

    state_next = (count_next != '0) ? S_ISSUE : S_IDLE;
    busy_next  = (count_next != '0) | led_ctrl_next;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_dbg       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      led_ctrl     <= 1'b0;
      led_addr     <= '0;
      led_data     <= '0;
      bad_addr_err <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      rr_dbg       <= rr_dbg_next;
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      fifo_count   <= count_next;
      led_ctrl     <= led_ctrl_next;
      led_addr     <= led_addr_next;
      led_data     <= led_data_next;
      bad_addr_err <= err_next;
      busy         <= busy_next;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= sel_addr;
      data_mem[wr_ptr] <= sel_wdata;
    end
  end

endmodule

// File: tb/tb_led_write_arbiter.sv
// Directed bench for led_write_arbiter with hand-computed expectations.
module tb_led_write_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        dbg_req;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_gnt;
  logic        led_ctrl;
  logic [7:0]  led_addr;
  logic [15:0] led_data;
  logic [2:0]  fifo_count;
  logic        busy;
  logic        err_clr;
  logic        bad_addr_err;

  int n_cmp = 0;
  int n_bad = 0;

  led_write_arbiter #(.FIFO_DEPTH(4), .ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .led_ctrl(led_ctrl), .led_addr(led_addr), .led_data(led_data),
    .fifo_count(fifo_count), .busy(busy),
    .err_clr(err_clr), .bad_addr_err(bad_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs are driven at edge+1, outputs sampled at edge+2
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
    dbg_req = 1'b0; dbg_addr = 8'h00; dbg_wdata = 16'h0000;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    check("rst_led_ctrl", 32'(led_ctrl), 32'd0);
    check("rst_led_addr", 32'(led_addr), 32'd0);
    check("rst_led_data", 32'(led_data), 32'd0);
    check("rst_count",    32'(fifo_count), 32'd0);
    check("rst_err",      32'(bad_addr_err), 32'd0);
    check("rst_busy",     32'(busy), 32'd0);
    tick(); tick();
    rst = 1'b0;

`ifdef LED_ARB_DBG_PRIORITY_EN
    // Strict debug priority: debug wins every contended cycle
    tick();
    cpu_req = 1'b1; cpu_addr = 8'h60; cpu_wdata = 16'h0001;
    dbg_req = 1'b1; dbg_addr = 8'h68; dbg_wdata = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("prio_dbg_gnt%0d", i), 32'(dbg_gnt), 32'd1);
      check($sformatf("prio_cpu_gnt%0d", i), 32'(cpu_gnt), 32'd0);
      if (i == 2) check("prio_led_data2", 32'(led_data), 32'h0002);
      tick();
    end
    idle_inputs();
    do_reset();
`else
    // Round-robin contention starting with CPU favoured after reset
    tick();
    cpu_req = 1'b1; cpu_addr = 8'h60; cpu_wdata = 16'h0001;
    dbg_req = 1'b1; dbg_addr = 8'h68; dbg_wdata = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_cpu_gnt%0d", i), 32'(cpu_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_dbg_gnt%0d", i), 32'(dbg_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i >= 2) begin
        check($sformatf("rr_led_ctrl%0d", i), 32'(led_ctrl), 32'd1);
        check($sformatf("rr_led_data%0d", i), 32'(led_data), (i % 2 == 0) ? 32'd1 : 32'd2);
      end
      tick();
    end
    idle_inputs();
    #1;
    check("rr_led_data4", 32'(led_data), 32'd1);
    check("rr_led_addr4", 32'(led_addr), 32'h60);
    tick(); #1;
    check("rr_led_data5", 32'(led_data), 32'd2);
    check("rr_led_addr5", 32'(led_addr), 32'h68);
    tick(); #1;
    check("rr_led_ctrl6", 32'(led_ctrl), 32'd0);
    check("rr_count6", 32'(fifo_count), 32'd0);
`endif

    // Single write: grant in N, strobe in N+2, drained by N+3
    tick();
    cpu_req = 1'b1; cpu_addr = 8'h64; cpu_wdata = 16'h00A5;
    #1;
    check("sw_gnt_N", 32'(cpu_gnt), 32'd1);
    check("sw_ctrl_N", 32'(led_ctrl), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("sw_ctrl_N1", 32'(led_ctrl), 32'd0);
    check("sw_count_N1", 32'(fifo_count), 32'd1);
    check("sw_busy_N1", 32'(busy), 32'd1);
    tick(); #1;
    check("sw_ctrl_N2", 32'(led_ctrl), 32'd1);
    check("sw_addr_N2", 32'(led_addr), 32'h64);
    check("sw_data_N2", 32'(led_data), 32'h00A5);
    check("sw_busy_N2", 32'(busy), 32'd1);
    tick(); #1;
    check("sw_ctrl_N3", 32'(led_ctrl), 32'd0);
    check("sw_count_N3", 32'(fifo_count), 32'd0);
    check("sw_busy_N3", 32'(busy), 32'd0);
    check("sw_hold_data_N3", 32'(led_data), 32'h00A5);

    // Six back-to-back CPU writes, order and occupancy preserved
    tick();
    for (int i = 0; i < 6; i++) begin
      cpu_req = 1'b1; cpu_addr = 8'h60; cpu_wdata = 16'(i + 1);
      #1;
      check($sformatf("bb_gnt%0d", i), 32'(cpu_gnt), 32'd1);
      check($sformatf("bb_cnt_le4_%0d", i), 32'(fifo_count <= 3'd4), 32'd1);
      if (i >= 2) check($sformatf("bb_data%0d", i), 32'(led_data), 32'(i - 1));
      tick();
    end
    idle_inputs();
    #1;
    check("bb_data6", 32'(led_data), 32'd5);
    check("bb_ctrl6", 32'(led_ctrl), 32'd1);
    tick(); #1;
    check("bb_data7", 32'(led_data), 32'd6);
    check("bb_ctrl7", 32'(led_ctrl), 32'd1);
    tick(); #1;
    check("bb_ctrl8", 32'(led_ctrl), 32'd0);
    check("bb_count8", 32'(fifo_count), 32'd0);

    // Bad address: consumed, dropped, sticky error; set beats clear
    tick();
    dbg_req = 1'b1; dbg_addr = 8'h6C; dbg_wdata = 16'hBEEF;
    #1;
    check("ba_gnt0", 32'(dbg_gnt), 32'd1);
    check("ba_err0", 32'(bad_addr_err), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("ba_err1", 32'(bad_addr_err), 32'd1);
    check("ba_count1", 32'(fifo_count), 32'd0);
    check("ba_ctrl1", 32'(led_ctrl), 32'd0);
    tick();
    dbg_req = 1'b1; dbg_addr = 8'h6C; err_clr = 1'b1;
    #1;
    check("ba_ctrl2", 32'(led_ctrl), 32'd0);
    check("ba_gnt2", 32'(dbg_gnt), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("ba_err3_setwins", 32'(bad_addr_err), 32'd1);
    check("ba_ctrl3", 32'(led_ctrl), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("ba_err4_cleared", 32'(bad_addr_err), 32'd0);

    // Reset in the middle of a burst discards everything
    tick();
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'b1; cpu_addr = 8'h68; cpu_wdata = 16'(7 + i);
      #1;
      check($sformatf("mr_gnt%0d", i), 32'(cpu_gnt), 32'd1);
      if (i < 2) tick();
    end
    #1;
    rst = 1'b1;
    #1;
    check("mr_ctrl", 32'(led_ctrl), 32'd0);
    check("mr_count", 32'(fifo_count), 32'd0);
    check("mr_data", 32'(led_data), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("mr_post_ctrl%0d", i), 32'(led_ctrl), 32'd0);
      check($sformatf("mr_post_count%0d", i), 32'(fifo_count), 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
